encode_session_ctrl: RTL and testbench
======================================

# encode_session_ctrl

Sequencer for the UART encode path. It collects a 4-byte payload from the UART receiver and streams the 32 payload bits one per clock into the convolutional encoder. It packs the 2-bit encoder outputs into a 64-bit coded word, then, on command, plays the 8 coded bytes back through the UART transmitter. It sits between `async_receiver`, `encoder_k3`, `async_transmitter` and the debounced button pulses, and replaces the ad-hoc counters in the board top level.

## Interface
Parameters:
- `ENC_LATENCY`, 1: clocks from `enc_bit` being driven to the matching `enc_out` being valid. Legal range 0–3.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `rx_data_ready` in 1: one-cycle strobe from the receiver; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `clear` in 1: debounced single-cycle pulse; aborts and returns to collection.
- `send` in 1: debounced single-cycle pulse; starts playback of the coded word.
- `enc_bit` out 1: bit presented to the encoder.
- `enc_out` in 2: encoder output; bit 0 is the first coded bit.
- `tx_start` out 1: one-cycle start strobe to the transmitter.
- `tx_data` out 8: byte to transmit; stable from the `tx_start` cycle until the transmitter drops `tx_busy`.
- `tx_busy` in 1: transmitter busy.
- `rx_count` out 3: payload bytes captured so far (0–4).
- `done` out 1: coded word valid and waiting for `send`.
- `active` out 1: high in ENCODE and SEND_*.
- `rx_drop` out 1: sticky; a received byte was discarded.

## Operation
- Registers:
  - `payload[31:0]`: byte n goes to `[8n+7:8n]`, n = arrival order 0..3.
  - `coded[63:0]`: pair for payload bit i goes to `[2i+1:2i]`.
  - `bit_idx[5:0]`, `byte_idx[2:0]`.
- **COLLECT**, the reset state:
  - On `rx_data_ready`, store `rx_data` at slot `rx_count`, then increment `rx_count`.
  - When the 4th byte is stored, go to ENCODE on the next cycle with `bit_idx`=0.
- **ENCODE**, lasting 32+`ENC_LATENCY` cycles:
  - On cycle t, drive `enc_bit` = `payload[t]` for t<32, else 0.
  - For t≥`ENC_LATENCY`, capture `enc_out` into `coded[2(t−ENC_LATENCY)+1 : 2(t−ENC_LATENCY)]`.
  - After the last capture, go to DONE.
- **DONE**: `done`=1. On `send`, go to SEND_LOAD with `byte_idx`=0.
- **SEND_LOAD**:
  - If `tx_busy`=0, drive `tx_data`=`coded[8·byte_idx+7 : 8·byte_idx]`, pulse `tx_start` for one cycle, and go to SEND_WAIT.
  - Otherwise hold in SEND_LOAD.
- **SEND_WAIT**:
  - Skip the first cycle unconditionally, then wait for `tx_busy`=0.
  - If `byte_idx`=7, go to COLLECT with `rx_count`=0 and `done`=0.
  - Otherwise increment `byte_idx` and go to SEND_LOAD.
- `enc_bit`=0 in every state except ENCODE t<32, so the encoder flushes to zero state between sessions.
- Priority is `rst` > `clear` > all others.
  - `clear` in any state: go to COLLECT, set `rx_count`=0, `done`=0, `tx_start`=0, clear `rx_drop`.
  - `payload` and `coded` are not zeroed by `clear`.
  - A byte already started in the transmitter completes on its own.
- Dropped input:
  - `rx_data_ready` outside COLLECT sets `rx_drop`; the byte is discarded.
  - `rx_data_ready` in the same cycle as `clear` is discarded without setting `rx_drop`.
- `send` outside DONE is ignored; it is not latched.

## Timing
- Reset values:
  - State COLLECT; `rx_count`=0, `done`=0, `active`=0, `rx_drop`=0.
  - `tx_start`=0, `tx_data`=0x00, `enc_bit`=0.
  - `payload`=0, `coded`=0, `bit_idx`=0, `byte_idx`=0.
- Receive to encode:
  - The 4th `rx_data_ready` at cycle c puts the FSM in ENCODE at c+1; `enc_bit`=`payload[0]` is driven during c+1.
  - `done` rises at c+1+32+`ENC_LATENCY`.
- Send to transmit:
  - `send` at cycle s (DONE) puts the FSM in SEND_LOAD at s+1.
  - The earliest `tx_start` is at s+1 when `tx_busy`=0.
  - `tx_start` is never high on consecutive cycles.
- Ordering: bytes leave LSB-first, `coded[7:0]` first; exactly 8 `tx_start` pulses per session.
- Outputs are registered.

## Test plan
The bench uses a stub encoder with `enc_out` = {`enc_bit`, ~`enc_bit`} registered (`ENC_LATENCY`=1), and a transmitter model that holds `tx_busy` for 20 cycles after each start.
- Reset, then RX 0xA5,0x00,0x00,0x00 → `rx_count` steps 1..4; `done`=1 exactly 33 cycles after ENCODE is entered; `coded`=0x5555_5555_5555_9966.
- `send` with the above → 8 `tx_start` pulses carrying 0x66,0x99,0x55,0x55,0x55,0x55,0x55,0x55, each issued only when `tx_busy`=0; then state COLLECT, `done`=0.
- A 5th byte during ENCODE → `rx_drop`=1, `coded` unchanged; the next `clear` → `rx_drop`=0.
- `clear` after 2 of 4 bytes, then 4 new bytes 0xFF,0xFF,0xFF,0xFF → `coded`=0xAAAA_AAAA_AAAA_AAAA.
- `clear` during the 3rd transmitted byte → no further `tx_start`, `rx_count`=0, state COLLECT next cycle; `clear`+`send` in the same cycle in DONE → no `tx_start`.
- `send` pulses in COLLECT and ENCODE → ignored; `rst` mid-ENCODE → all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/encode_session_ctrl.sv
// encode_session_ctrl: collects a 4-byte payload from the UART receiver and
// streams its 32 bits one per clock into the convolutional encoder. It packs
// the 2-bit encoder outputs into a 64-bit coded word, then, on send, plays the
// 8 coded bytes back through the UART transmitter, LSB byte first.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// COLLECT    | capturing payload bytes, rx_count = bytes held so far
// ENCODE     | streaming payload bits to the encoder, capturing coded pairs
// DONE       | coded word valid, waiting for send
// SEND_LOAD  | byte byte_idx queued; tx_start issued once the transmitter idles
// SEND_WAIT  | byte in flight; one blind cycle, then wait for tx_busy low
//
// tx_start is a registered output, so the start for the next byte is issued
// one cycle early: whenever the FSM moves into SEND_LOAD having just seen
// tx_busy low, tx_start and tx_data are loaded on that same edge. The
// transmitter only raises tx_busy in response to our own tx_start, so
// tx_busy low in one cycle guarantees it is still low in the next.
module encode_session_ctrl #(
   parameter int unsigned ENC_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_data_ready,
   input  logic [7:0] rx_data,
   input  logic       clear,
   input  logic       send,
   output logic       enc_bit,
   input  logic [1:0] enc_out,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   output logic [2:0] rx_count,
   output logic       done,
   output logic       active,
   output logic       rx_drop
);

   localparam logic [2:0] ST_COLLECT   = 3'd0;
   localparam logic [2:0] ST_ENCODE    = 3'd1;
   localparam logic [2:0] ST_DONE      = 3'd2;
   localparam logic [2:0] ST_SEND_LOAD = 3'd3;
   localparam logic [2:0] ST_SEND_WAIT = 3'd4;

   // ENCODE runs from t = 0 to t = 31 + ENC_LATENCY; the last capture ends it.
   localparam logic [5:0] LAT    = 6'(ENC_LATENCY);
   localparam logic [5:0] LAST_T = 6'(31 + ENC_LATENCY);

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [31:0] payload;
   logic [63:0] coded;
   logic [5:0]  bit_idx;
   logic [2:0]  byte_idx;
   logic [2:0]  byte_nxt;
   logic        wait_first;
   logic [4:0]  cap_idx;
   logic [4:0]  bit_nxt;

   assign byte_nxt = byte_idx + 3'd1;
   assign cap_idx  = bit_idx[4:0] - LAT[4:0];
   assign bit_nxt  = bit_idx[4:0] + 5'd1;

   // Next-state decode; clear overrides every transition.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_COLLECT:   if (rx_data_ready && rx_count == 3'd3) state_nxt = ST_ENCODE;
         ST_ENCODE:    if (bit_idx == LAST_T) state_nxt = ST_DONE;
         ST_DONE:      if (send) state_nxt = ST_SEND_LOAD;
         ST_SEND_LOAD: if (tx_start) state_nxt = ST_SEND_WAIT;
         ST_SEND_WAIT: begin
            if (!wait_first && !tx_busy)
               state_nxt = (byte_idx == 3'd7) ? ST_COLLECT : ST_SEND_LOAD;
         end
         default:      state_nxt = ST_COLLECT;
      endcase
      if (clear) state_nxt = ST_COLLECT;
   end

   // State register plus all datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_COLLECT;
         active     <= 1'b0;
         rx_count   <= 3'd0;
         done       <= 1'b0;
         rx_drop    <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
         enc_bit    <= 1'b0;
         payload    <= 32'h0;
         coded      <= 64'h0;
         bit_idx    <= 6'd0;
         byte_idx   <= 3'd0;
         wait_first <= 1'b0;
      end else begin
         state  <= state_nxt;
         active <= (state_nxt == ST_ENCODE) || (state_nxt == ST_SEND_LOAD) ||
                   (state_nxt == ST_SEND_WAIT);
         if (clear) begin
            // payload and coded are kept; an in-flight byte finishes on its own.
            rx_count   <= 3'd0;
            done       <= 1'b0;
            rx_drop    <= 1'b0;
            tx_start   <= 1'b0;
            enc_bit    <= 1'b0;
            bit_idx    <= 6'd0;
            wait_first <= 1'b0;
         end else begin
            tx_start <= 1'b0;
            enc_bit  <= 1'b0;
            if (rx_data_ready && state != ST_COLLECT) rx_drop <= 1'b1;
            case (state)
               ST_COLLECT: begin
                  if (rx_data_ready) begin
                     payload[{rx_count[1:0], 3'b000} +: 8] <= rx_data;
                     rx_count <= rx_count + 3'd1;
                     if (rx_count == 3'd3) begin
                        bit_idx <= 6'd0;
                        enc_bit <= payload[0];
                     end
                  end
               end
               ST_ENCODE: begin
                  enc_bit <= (bit_idx < 6'd31) ? payload[bit_nxt] : 1'b0;
                  if (bit_idx >= LAT) coded[{cap_idx, 1'b0} +: 2] <= enc_out;
                  if (bit_idx == LAST_T) begin
                     done    <= 1'b1;
                     bit_idx <= 6'd0;
                  end else begin
                     bit_idx <= bit_idx + 6'd1;
                  end
               end
               ST_DONE: begin
                  if (send) begin
                     byte_idx <= 3'd0;
                     if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= coded[7:0];
                     end
                  end
               end
               ST_SEND_LOAD: begin
                  if (tx_start) begin
                     wait_first <= 1'b1;
                  end else if (!tx_busy) begin
                     tx_start <= 1'b1;
                     tx_data  <= coded[{byte_idx, 3'b000} +: 8];
                  end
               end
               ST_SEND_WAIT: begin
                  if (wait_first) begin
                     wait_first <= 1'b0;
                  end else if (!tx_busy) begin
                     if (byte_idx == 3'd7) begin
                        rx_count <= 3'd0;
                        done     <= 1'b0;
                     end else begin
                        byte_idx <= byte_nxt;
                        tx_start <= 1'b1;
                        tx_data  <= coded[{byte_nxt, 3'b000} +: 8];
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_encode_session_ctrl.sv
// Bench for encode_session_ctrl with a registered stub encoder
// (enc_out = {enc_bit, ~enc_bit}) and a transmitter that stays busy for
// 20 cycles after each start.
module tb_encode_session_ctrl;

   localparam int LAT = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_data_ready;
   logic [7:0] rx_data;
   logic       clear;
   logic       send;
   logic       enc_bit;
   logic [1:0] enc_out;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic [2:0] rx_count;
   logic       done;
   logic       active;
   logic       rx_drop;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   encode_session_ctrl #(.ENC_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
      .clear(clear), .send(send), .enc_bit(enc_bit), .enc_out(enc_out),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .rx_count(rx_count), .done(done), .active(active), .rx_drop(rx_drop)
   );

   // stub encoder, one cycle of latency
   always @(posedge clk) begin
      if (rst) enc_out <= 2'b00;
      else     enc_out <= {enc_bit, ~enc_bit};
   end

   // transmitter model
   int busy_cnt = 0;
   always @(posedge clk) begin
      if (tx_start)          busy_cnt <= 20;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // transmit monitor: records bytes and checks handshake rules
   logic [7:0] txq[$];
   logic       prev_start = 1'b0;
   logic [7:0] held = 8'h00;
   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         txq.push_back(tx_data);
         chk("busy_at_start", tx_busy, 0);
         chk("start_consecutive", prev_start, 0);
         held = tx_data;
      end else if (tx_busy) begin
         chk("tx_data_hold", tx_data, held);
      end
      prev_start = (tx_start === 1'b1);
   end

   function automatic logic [63:0] model_coded(input logic [31:0] p);
      logic [63:0] w;
      w = 64'h0;
      for (int i = 0; i < 32; i++) w[2*i +: 2] = p[i] ? 2'b10 : 2'b01;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_data = b;
      rx_data_ready = 1'b1;
      tick();
      rx_data_ready = 1'b0;
   endtask

   // Loads 4 bytes, then follows ENCODE until done rises.
   task automatic load_payload(input logic [31:0] p, input int gap_max,
                               input bit poke_send, input bit poke_rx);
      int n;
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(gap_max, 0)) tick();
         rx_byte(p[8*i +: 8]);
         chk("rx_count", rx_count, i + 1);
      end
      chk("active_encode", active, 1);
      n = 0;
      while (!done && n < 200) begin
         if (n < 32) chk("enc_bit", enc_bit, p[n]);
         else        chk("enc_bit_flush", enc_bit, 0);
         send          = poke_send && (n == 5);
         rx_data_ready = poke_rx && (n == 8);
         rx_data       = 8'h77;
         tick();
         n++;
      end
      send = 1'b0;
      rx_data_ready = 1'b0;
      chk("done_latency", n, 32 + LAT);
      if (poke_rx) begin
         chk("rx_drop_set", rx_drop, 1);
         chk("rx_count_hold", rx_count, 4);
      end
   endtask

   task automatic play(output logic [63:0] w);
      int  n;
      logic busy_before;
      txq.delete();
      busy_before = tx_busy;
      send = 1'b1;
      tick();
      send = 1'b0;
      if (!busy_before) chk("tx_start_first", tx_start, 1);
      n = 0;
      while ((txq.size() < 8 || active) && n < 3000) begin
         tick();
         n++;
      end
      repeat (30) tick();
      w = 64'h0;
      for (int i = 0; i < txq.size() && i < 8; i++) w[8*i +: 8] = txq[i];
      chk("pulse_count", txq.size(), 8);
      chk("done_after", done, 0);
      chk("active_after", active, 0);
      chk("rx_count_after", rx_count, 0);
   endtask

   typedef struct {
      logic [31:0] payload;
      logic [63:0] coded;
   } vec_t;

   vec_t vt[4];

   initial begin
      logic [63:0] w;
      logic [31:0] p;
      int n;

      vt[0] = '{32'h0000_00A5, 64'h5555_5555_5555_9966};
      vt[1] = '{32'hFFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA};
      vt[2] = '{32'h0000_0000, 64'h5555_5555_5555_5555};
      vt[3] = '{32'hFF00_F00F, 64'hAAAA_5555_AA55_55AA};

      rst = 1'b1; rx_data_ready = 1'b0; rx_data = 8'h00; clear = 1'b0; send = 1'b0;
      repeat (3) tick();
      chk("rst_rx_count", rx_count, 0);
      chk("rst_done", done, 0);
      chk("rst_active", active, 0);
      chk("rst_rx_drop", rx_drop, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_enc_bit", enc_bit, 0);
      rst = 1'b0;

      // send in COLLECT is ignored
      send = 1'b1; tick(); send = 1'b0;
      repeat (5) tick();
      chk("send_collect_active", active, 0);
      chk("send_collect_tx", txq.size(), 0);

      // table vectors; the first one also pokes send during ENCODE
      for (int v = 0; v < 4; v++) begin
         txq.delete();
         load_payload(vt[v].payload, 0, (v == 0), 1'b0);
         chk("no_tx_before_send", txq.size(), 0);
         chk("done_high", done, 1);
         play(w);
         chk("coded_vec", w, vt[v].coded);
      end

      // 5th byte during ENCODE is dropped, coded unaffected
      p = 32'h1234_5678;
      load_payload(p, 1, 1'b0, 1'b1);
      play(w);
      chk("coded_after_drop", w, model_coded(p));
      chk("rx_drop_sticky", rx_drop, 1);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("rx_drop_cleared", rx_drop, 0);

      // clear after two bytes restarts collection
      rx_byte(8'h12);
      rx_byte(8'h34);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clear_rx_count", rx_count, 0);
      load_payload(32'hFFFF_FFFF, 0, 1'b0, 1'b0);
      play(w);
      chk("coded_after_clear", w, 64'hAAAA_AAAA_AAAA_AAAA);

      // clear during the third transmitted byte
      p = $urandom;
      load_payload(p, 0, 1'b0, 1'b0);
      txq.delete();
      send = 1'b1; tick(); send = 1'b0;
      n = 0;
      while (txq.size() < 3 && n < 500) begin tick(); n++; end
      repeat (5) tick();
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clr_send_rx_count", rx_count, 0);
      chk("clr_send_active", active, 0);
      chk("clr_send_done", done, 0);
      repeat (100) tick();
      chk("clr_send_pulses", txq.size(), 3);

      // clear + send + rx byte together in DONE
      p = $urandom;
      load_payload(p, 0, 1'b0, 1'b0);
      txq.delete();
      clear = 1'b1; send = 1'b1; rx_data_ready = 1'b1; rx_data = 8'h5A;
      tick();
      clear = 1'b0; send = 1'b0; rx_data_ready = 1'b0;
      chk("clr_done_done", done, 0);
      chk("clr_done_tx_start", tx_start, 0);
      chk("clr_rx_no_drop", rx_drop, 0);
      chk("clr_rx_discard", rx_count, 0);
      repeat (40) tick();
      chk("clr_done_pulses", txq.size(), 0);

      // reset in the middle of ENCODE
      for (int i = 0; i < 4; i++) rx_byte(8'hFF);
      repeat (4) tick();
      rx_data_ready = 1'b1; tick(); rx_data_ready = 1'b0;
      chk("pre_rst_enc_bit", enc_bit, 1);
      chk("pre_rst_drop", rx_drop, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_rx_count", rx_count, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_active", active, 0);
      chk("mid_rst_rx_drop", rx_drop, 0);
      chk("mid_rst_tx_start", tx_start, 0);
      chk("mid_rst_tx_data", tx_data, 0);
      chk("mid_rst_enc_bit", enc_bit, 0);

      // randomized sessions against the reference model
      for (int k = 0; k < 6; k++) begin
         p = $urandom;
         load_payload(p, 3, 1'b0, 1'b0);
         repeat ($urandom_range(10, 0)) tick();
         play(w);
         chk("coded_rand", w, model_coded(p));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule
